// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch FSM states, decoded-instruction record and opcode constants
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH_OP   = 2'd0,
      FETCH_REG  = 2'd1,
      FETCH_IMM1 = 2'd2,
      FETCH_IMM2 = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [4:0]  opcode;
      logic [2:0]  dst;
      logic [2:0]  src1;
      logic [2:0]  src2;
      logic        hasimm1;
      logic        hasimm2;
      logic [7:0]  imm1;
      logic [7:0]  imm2;
      logic [15:0] pc_next;
      logic        illegal;
   } instr_t;

   localparam logic [4:0] OP_CMP = 5'd8;
   localparam logic [4:0] OP_JMP = 5'd15;
   localparam logic [4:0] OP_CAL = 5'd16;
   localparam logic [4:0] OP_RET = 5'd17;
   localparam logic [4:0] OP_PST = 5'd24;
   localparam logic [4:0] OP_PLD = 5'd25;
   localparam logic [4:0] OP_HLT = 5'd31;

   // Opcodes 26..30 are unassigned; they are still queued, only flagged.
   function automatic logic is_illegal(input logic [4:0] op);
      return (op >= 5'd26) && (op <= 5'd30);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of decoded instructions with flush
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  instr_t                     push_data_i,
   input  logic                       pop_i,
   output instr_t                     head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   instr_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic            do_push;
   logic            do_pop;

   always_comb begin
      do_pop  = pop_i & (count_q != '0);
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      do_push = push_i & ((count_q < CW'(DEPTH)) | do_pop);
      count_d = count_q;
      if (do_push & ~do_pop) begin
         count_d = count_q + CW'(1);
      end else if (~do_push & do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - byte-serial instruction fetch and decode into a prefetch FIFO
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        sync_rst,
   output logic [15:0] rom_addr,
   input  logic [7:0]  rom_data,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   input  logic        halt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_opcode,
   output logic [2:0]  out_dst,
   output logic [2:0]  out_src1,
   output logic [2:0]  out_src2,
   output logic        out_hasimm1,
   output logic        out_hasimm2,
   output logic [7:0]  out_imm1,
   output logic [7:0]  out_imm2,
   output logic [15:0] out_pc_next,
   output logic        out_illegal
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [15:0]   pc_q, pc_d;
   logic [4:0]    opcode_q, opcode_d;
   logic [2:0]    dst_q, dst_d;
   logic [2:0]    src1_q, src1_d;
   logic [2:0]    src2_q, src2_d;
   logic          hasimm1_q, hasimm1_d;
   logic          hasimm2_q, hasimm2_d;
   logic [7:0]    imm1_q, imm1_d;

   logic [15:0]   pc_inc;
   logic          push;
   logic          pop;
   logic          flush;
   logic          has_room;
   instr_t        push_data;
   instr_t        head;
   logic [CW-1:0] count;

   assign pc_inc   = pc_q + 16'd1;
   assign has_room = (count < CW'(FIFO_DEPTH));

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      opcode_d  = opcode_q;
      dst_d     = dst_q;
      src1_d    = src1_q;
      src2_d    = src2_q;
      hasimm1_d = hasimm1_q;
      hasimm2_d = hasimm2_q;
      imm1_d    = imm1_q;
      push      = 1'b0;
      flush     = 1'b0;
      // Redirect wins over halt, push and pop; no ROM byte is consumed.
      if (redirect_valid) begin
         flush   = 1'b1;
         pc_d    = redirect_pc;
         state_d = FETCH_OP;
      end else if (!halt) begin
         unique case (state_q)
            FETCH_OP: begin
               if (has_room) begin
                  opcode_d = rom_data[4:0];
                  dst_d    = rom_data[7:5];
                  pc_d     = pc_inc;
                  state_d  = FETCH_REG;
               end
            end
            FETCH_REG: begin
               hasimm1_d = rom_data[7];
               hasimm2_d = rom_data[6];
               src1_d    = rom_data[5:3];
               src2_d    = rom_data[2:0];
               pc_d      = pc_inc;
               if (rom_data[7]) begin
                  state_d = FETCH_IMM1;
               end else if (rom_data[6]) begin
                  state_d = FETCH_IMM2;
               end else begin
                  push    = 1'b1;
                  state_d = FETCH_OP;
               end
            end
            FETCH_IMM1: begin
               imm1_d = rom_data;
               pc_d   = pc_inc;
               if (hasimm2_q) begin
                  state_d = FETCH_IMM2;
               end else begin
                  push    = 1'b1;
                  state_d = FETCH_OP;
               end
            end
            FETCH_IMM2: begin
               pc_d    = pc_inc;
               push    = 1'b1;
               state_d = FETCH_OP;
            end
            default: state_d = FETCH_OP;
         endcase
      end
   end

   // The record is assembled from next-state fields so the final byte lands in it directly.
   always_comb begin
      push_data         = '0;
      push_data.opcode  = opcode_d;
      push_data.dst     = dst_d;
      push_data.src1    = src1_d;
      push_data.src2    = src2_d;
      push_data.hasimm1 = hasimm1_d;
      push_data.hasimm2 = hasimm2_d;
      push_data.imm1    = hasimm1_d ? imm1_d : 8'h00;
      push_data.imm2    = hasimm2_d ? rom_data : 8'h00;
      push_data.pc_next = pc_inc;
      push_data.illegal = is_illegal(opcode_d);
   end

   always_ff @(posedge clk or posedge sync_rst) begin
      if (sync_rst) begin
         state_q   <= FETCH_OP;
         pc_q      <= 16'h0000;
         opcode_q  <= '0;
         dst_q     <= '0;
         src1_q    <= '0;
         src2_q    <= '0;
         hasimm1_q <= 1'b0;
         hasimm2_q <= 1'b0;
         imm1_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         opcode_q  <= opcode_d;
         dst_q     <= dst_d;
         src1_q    <= src1_d;
         src2_q    <= src2_d;
         hasimm1_q <= hasimm1_d;
         hasimm2_q <= hasimm2_d;
         imm1_q    <= imm1_d;
      end
   end

   assign out_valid = (count != '0) & ~halt;
   assign pop       = out_valid & out_ready & ~redirect_valid;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (sync_rst),
      .flush_i     (flush),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count)
   );

   assign rom_addr    = pc_q;
   assign out_opcode  = head.opcode;
   assign out_dst     = head.dst;
   assign out_src1    = head.src1;
   assign out_src2    = head.src2;
   assign out_hasimm1 = head.hasimm1;
   assign out_hasimm2 = head.hasimm2;
   assign out_imm1    = head.imm1;
   assign out_imm2    = head.imm2;
   assign out_pc_next = head.pc_next;
   assign out_illegal = head.illegal;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        sync_rst = 1'b1;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halt = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_opcode;
   logic [2:0]  out_dst;
   logic [2:0]  out_src1;
   logic [2:0]  out_src2;
   logic        out_hasimm1;
   logic        out_hasimm2;
   logic [7:0]  out_imm1;
   logic [7:0]  out_imm2;
   logic [15:0] out_pc_next;
   logic        out_illegal;

   logic [7:0]  rom [0:65535];
   int          compared = 0;
   int          mismatched = 0;

   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   instr_fetch #(.FIFO_DEPTH(2)) dut (
      .clk            (clk),
      .sync_rst       (sync_rst),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_opcode     (out_opcode),
      .out_dst        (out_dst),
      .out_src1       (out_src1),
      .out_src2       (out_src2),
      .out_hasimm1    (out_hasimm1),
      .out_hasimm2    (out_hasimm2),
      .out_imm1       (out_imm1),
      .out_imm2       (out_imm2),
      .out_pc_next    (out_pc_next),
      .out_illegal    (out_illegal)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench just after a rising edge with reset released: the current cycle is cycle 0.
   task automatic do_reset();
      sync_rst       = 1'b1;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      out_ready      = 1'b0;
      for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
      tick();
      tick();
      check("rst_valid",   64'(out_valid), 64'h0);
      check("rst_addr",    64'(rom_addr), 64'h0);
      check("rst_fields",  64'({out_opcode, out_dst, out_pc_next}), 64'h0);
      sync_rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int k;

      // 3-byte instruction with imm1 only
      do_reset();
      rom[0] = 8'h21; rom[1] = 8'h80; rom[2] = 8'h05;
      out_ready = 1'b1;
      check("t1_addr0", 64'(rom_addr), 64'h0);
      tick();
      check("t1_c1_valid", 64'(out_valid), 64'h0);
      tick();
      check("t1_c2_valid", 64'(out_valid), 64'h0);
      tick();
      check("t1_c3_valid", 64'(out_valid), 64'h1);
      check("t1_fields", 64'({out_opcode, out_dst, out_hasimm1, out_imm1, out_hasimm2, out_imm2, out_pc_next, out_illegal}),
            64'({5'd1, 3'd1, 1'b1, 8'h05, 1'b0, 8'h00, 16'h0003, 1'b0}));

      // 4-byte instruction with both immediates, single entry
      do_reset();
      rom[0] = 8'h00; rom[1] = 8'hC0; rom[2] = 8'h12; rom[3] = 8'h34;
      tick(); tick(); tick();
      check("t2_c3_valid", 64'(out_valid), 64'h0);
      tick();
      check("t2_c4_valid", 64'(out_valid), 64'h1);
      check("t2_fields", 64'({out_hasimm1, out_hasimm2, out_imm1, out_imm2, out_pc_next}),
            64'({1'b1, 1'b1, 8'h12, 8'h34, 16'h0004}));
      out_ready = 1'b1;
      tick();
      check("t2_single", 64'(out_valid), 64'h0);

      // six 2-byte instructions, backpressure then drain
      do_reset();
      for (int i = 0; i < 6; i++) begin
         rom[2*i]   = {3'(i), 5'(i + 1)};
         rom[2*i+1] = {2'b00, 3'(i), 3'(7 - i)};
      end
      for (int i = 0; i < 8; i++) tick();
      check("t3_stall_addr", 64'(rom_addr), 64'h0004);
      check("t3_stall_valid", 64'(out_valid), 64'h1);
      out_ready = 1'b1;
      k = 0;
      for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
         if (out_valid) begin
            check($sformatf("t3_entry%0d", k),
                  64'({out_opcode, out_dst, out_src1, out_src2, out_pc_next}),
                  64'({5'(k + 1), 3'(k), 3'(k), 3'(7 - k), 16'(2 * k + 2)}));
            k++;
         end
         tick();
      end
      check("t3_delivered", 64'(k), 64'd6);

      // redirect during FETCH_IMM1 with a queued entry
      do_reset();
      rom[0] = 8'h01; rom[1] = 8'h00;
      rom[2] = 8'h02; rom[3] = 8'h80; rom[4] = 8'h55;
      rom[16'h40] = 8'h07; rom[16'h41] = 8'h09;
      for (int i = 0; i < 4; i++) tick();
      check("t4_pre_addr", 64'(rom_addr), 64'h0004);
      check("t4_pre_valid", 64'(out_valid), 64'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      tick();
      redirect_valid = 1'b0;
      check("t4_flushed", 64'(out_valid), 64'h0);
      check("t4_addr", 64'(rom_addr), 64'h0040);
      tick(); tick();
      check("t4_new_valid", 64'(out_valid), 64'h1);
      check("t4_new_fields", 64'({out_opcode, out_src1, out_src2, out_pc_next}),
            64'({5'd7, 3'd1, 3'd1, 16'h0042}));

      // pc wrap and illegal opcode flag
      do_reset();
      rom[16'hFFFF] = 8'h1F; rom[1] = 8'h1A;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFF;
      tick();
      redirect_valid = 1'b0;
      check("t5_addr", 64'(rom_addr), 64'hFFFF);
      tick(); tick();
      check("t5_hlt", 64'({out_valid, out_opcode, out_pc_next, out_illegal}),
            64'({1'b1, 5'd31, 16'h0001, 1'b0}));
      tick(); tick();
      check("t5_illegal", 64'({out_valid, out_opcode, out_pc_next, out_illegal}),
            64'({1'b1, 5'd26, 16'h0003, 1'b1}));

      // halt mid FETCH_REG for five cycles
      do_reset();
      rom[0] = 8'h05; rom[1] = 8'h00; rom[2] = 8'h06;
      out_ready = 1'b1;
      tick();
      halt = 1'b1;
      check("t6_h0", 64'({rom_addr, out_valid}), 64'({16'h0001, 1'b0}));
      for (int i = 1; i < 5; i++) begin
         tick();
         check($sformatf("t6_h%0d", i), 64'({rom_addr, out_valid}), 64'({16'h0001, 1'b0}));
      end
      tick();
      halt = 1'b0;
      check("t6_resume_addr", 64'(rom_addr), 64'h0001);
      tick();
      check("t6_out", 64'({out_valid, out_opcode, out_pc_next}), 64'({1'b1, 5'd5, 16'h0002}));
      halt = 1'b1;
      #1;
      check("t6_hidden", 64'(out_valid), 64'h0);
      halt = 1'b0;
      #1;
      check("t6_shown", 64'({out_valid, out_opcode}), 64'({1'b1, 5'd5}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
